decode_stage_pipe: RTL and testbench

- Registered, handshaked successor to the combinational RV32I instruction decoder.
- Decodes one instruction per cycle into the ID/EX pipeline register.
- Adds valid/ready flow control, flush, a load-use interlock that inserts one bubble, defined zero values for every unused field, and a stall counter.
- Sits between the IF/ID register and the execute stage.

---
 rtl/decode_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I decoder feeding the ID/EX register, with a load-use interlock and flush.
// Latency: one cycle from acceptance (in_valid && in_ready) to out_valid.
// Backpressure: bundle holds while out_valid && !out_ready; in_ready drops on stall, hazard, flush or reset.
// Optional: define ILLEGAL_DETECT_EN to add the illegal output and suppress side effects of bad encodings.
module decode_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int ALU_CODE_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           Instruction,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  ALUSrcA,
  output logic                  Jump,
  output logic                  JALR,
  output logic                  SB_type,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CODE_W-1:0] ALUCode,
  output logic [2:0]            funct3,
  output logic [4:0]            rs1Addr,
  output logic [4:0]            rs2Addr,
  output logic [4:0]            rdAddr,
  output logic [XLEN-1:0]       Imm,
  output logic [XLEN-1:0]       offset,
  output logic [CNT_W-1:0]      stall_count
`ifdef ILLEGAL_DETECT_EN
  ,
  output logic                  illegal
`endif
);

  // Major opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operation codes understood by the execute stage
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = ALU_CODE_W'(0);
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = ALU_CODE_W'(1);
  localparam logic [ALU_CODE_W-1:0] ALU_LUI  = ALU_CODE_W'(2);
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = ALU_CODE_W'(3);
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = ALU_CODE_W'(4);
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = ALU_CODE_W'(5);
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = ALU_CODE_W'(6);
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = ALU_CODE_W'(7);
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = ALU_CODE_W'(8);
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = ALU_CODE_W'(9);
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = ALU_CODE_W'(10);

  // Everything the execute stage sees, kept together so capture/clear is one assignment
  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  alu_src_a;
    logic                  jump;
    logic                  jalr;
    logic                  sb_type;
    logic [1:0]            alu_src_b;
    logic [ALU_CODE_W-1:0] alu_code;
    logic [2:0]            funct3;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       offset;
  } bundle_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r;
  logic       is_i;
  logic       is_sb;
  logic       is_lw;
  logic       is_jalr;
  logic       is_sw;
  logic       is_lui;
  logic       is_auipc;
  logic       is_jal;
  logic       is_shift_i;

  bundle_t    dec;
  bundle_t    bundle_q;
  logic       valid_q;
  logic [CNT_W-1:0] stall_q;
  logic       hazard;
  logic       accept;

  assign op  = Instruction[6:0];
  assign f3  = Instruction[14:12];
  assign f7  = Instruction[31:25];

  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_I);
  assign is_sb    = (op == OP_SB);
  assign is_lw    = (op == OP_LW);
  assign is_jalr  = (op == OP_JALR);
  assign is_sw    = (op == OP_SW);
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);

  // Immediate shifts carry only a shamt; funct7 bits above it select SRA and must not leak into Imm
  assign is_shift_i = is_i & ((f3 == 3'b001) | (f3 == 3'b101));

`ifdef ILLEGAL_DETECT_EN
  logic known_op;
  logic dec_illegal;
  assign known_op    = is_r | is_i | is_sb | is_lw | is_jalr | is_sw | is_lui | is_auipc | is_jal;
  assign dec_illegal = ~known_op | (is_r & (f7 != 7'b0000000) & (f7 != 7'b0100000));
`endif

  // Combinational decode of the incoming word; every field has a defined value for every opcode
  always_comb begin
    dec            = '0;
    dec.mem_to_reg = is_lw;
    dec.mem_read   = is_lw;
    dec.mem_write  = is_sw;
    dec.reg_write  = is_r | is_i | is_lw | is_jalr | is_lui | is_auipc | is_jal;
    dec.jump       = is_jal | is_jalr;
    dec.jalr       = is_jalr;
    dec.sb_type    = is_sb;
    dec.alu_src_a  = is_jal | is_jalr | is_auipc;
    dec.alu_src_b  = {is_jal | is_jalr, ~(is_r | is_jal | is_jalr)};
    dec.funct3     = f3;

    // Register addresses only where the format defines them so unused fields never alias a hazard
    dec.rs1 = (is_r | is_i | is_lw | is_sw | is_sb | is_jalr) ? Instruction[19:15] : 5'd0;
    dec.rs2 = (is_r | is_sw | is_sb) ? Instruction[24:20] : 5'd0;
    dec.rd  = (is_sw | is_sb) ? 5'd0 : Instruction[11:7];

    // ALU operation: bit30 distinguishes SUB only for R-type, SRA for both R and I
    if (is_r | is_i) begin
      case (f3)
        3'b000:  dec.alu_code = (is_r & Instruction[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  dec.alu_code = ALU_SLL;
        3'b010:  dec.alu_code = ALU_SLT;
        3'b011:  dec.alu_code = ALU_SLTU;
        3'b100:  dec.alu_code = ALU_XOR;
        3'b101:  dec.alu_code = Instruction[30] ? ALU_SRA : ALU_SRL;
        3'b110:  dec.alu_code = ALU_OR;
        default: dec.alu_code = ALU_AND;
      endcase
    end else if (is_lui) begin
      dec.alu_code = ALU_LUI;
    end

    // Operand immediate
    if (is_shift_i) begin
      dec.imm = XLEN'(Instruction[25:20]);
    end else if (is_i | is_lw) begin
      dec.imm = XLEN'($signed(Instruction[31:20]));
    end else if (is_sw) begin
      dec.imm = XLEN'($signed({Instruction[31:25], Instruction[11:7]}));
    end else if (is_lui | is_auipc) begin
      dec.imm = XLEN'($signed({Instruction[31:12], 12'b0}));
    end

    // Control-transfer offset
    if (is_jalr) begin
      dec.offset = XLEN'($signed(Instruction[31:20]));
    end else if (is_jal) begin
      dec.offset = XLEN'($signed({Instruction[31], Instruction[19:12], Instruction[20],
                                  Instruction[30:21], 1'b0}));
    end else if (is_sb) begin
      dec.offset = XLEN'($signed({Instruction[31], Instruction[7], Instruction[30:25],
                                  Instruction[11:8], 1'b0}));
    end

`ifdef ILLEGAL_DETECT_EN
    // A bad encoding still travels down the pipe, but must not write state or redirect
    if (dec_illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.jump      = 1'b0;
    end
`endif
  end

  // Load in ID/EX whose destination feeds the incoming instruction: hold it back one cycle
  assign hazard = valid_q & bundle_q.mem_read & (bundle_q.rd != 5'd0) & in_valid &
                  ((bundle_q.rd == dec.rs1) | (bundle_q.rd == dec.rs2));

  assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush & ~reset;
  assign accept   = in_valid & in_ready;

  // ID/EX register: flush kills everything, accept captures, consumption without refill makes a zeroed bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      bundle_q <= dec;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end
  end

  // Count inserted bubbles: only when the load actually leaves and the stall is what blocks the input
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (hazard & out_ready & ~flush & (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_DETECT_EN
  logic illegal_q;

  // Illegal flag follows the bundle it describes
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
    end else if (out_ready) begin
      illegal_q <= 1'b0;
    end
  end

  assign illegal = illegal_q;
`endif

  assign out_valid   = valid_q;
  assign MemtoReg    = bundle_q.mem_to_reg;
  assign RegWrite    = bundle_q.reg_write;
  assign MemWrite    = bundle_q.mem_write;
  assign MemRead     = bundle_q.mem_read;
  assign ALUSrcA     = bundle_q.alu_src_a;
  assign Jump        = bundle_q.jump;
  assign JALR        = bundle_q.jalr;
  assign SB_type     = bundle_q.sb_type;
  assign ALUSrcB     = bundle_q.alu_src_b;
  assign ALUCode     = bundle_q.alu_code;
  assign funct3      = bundle_q.funct3;
  assign rs1Addr     = bundle_q.rs1;
  assign rs2Addr     = bundle_q.rs2;
  assign rdAddr      = bundle_q.rd;
  assign Imm         = bundle_q.imm;
  assign offset      = bundle_q.offset;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed scenarios plus randomized traffic against a reference decoder/pipe model.
// Latency: expects decoded bundle one cycle after acceptance.
// Backpressure: randomly withholds out_ready and injects flushes.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instruction;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA, Jump, JALR, SB_type;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUCode;
  logic [2:0]  funct3;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [31:0] Imm, offset;
  logic [15:0] stall_count;
`ifdef ILLEGAL_DETECT_EN
  logic        illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(32), .ALU_CODE_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instruction(Instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrcA(ALUSrcA), .Jump(Jump), .JALR(JALR), .SB_type(SB_type), .ALUSrcB(ALUSrcB),
    .ALUCode(ALUCode), .funct3(funct3), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
    .Imm(Imm), .offset(offset), .stall_count(stall_count)
`ifdef ILLEGAL_DETECT_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    logic        mem_to_reg, reg_write, mem_write, mem_read, alu_src_a, jump, jalr, sb_type;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_code;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, offset;
    logic        illegal;
  } bnd_t;

  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_SRA  = 32'h40B55533;
  localparam logic [31:0] I_SRAI = 32'h4015D593;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_ADD2 = 32'h00728333;
  localparam logic [31:0] I_JAL  = 32'hFFDFF0EF;

  function automatic bnd_t dut_bundle();
    bnd_t b;
    b = '{MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA, Jump, JALR, SB_type,
          ALUSrcB, ALUCode, funct3, rs1Addr, rs2Addr, rdAddr, Imm, offset, 1'b0};
`ifdef ILLEGAL_DETECT_EN
    b.illegal = illegal;
`endif
    return b;
  endfunction

  // Reference ALU selection from the funct3 table, then the bit30 variants
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic r_type);
    int tbl[8] = '{0, 6, 9, 10, 4, 7, 5, 3};
    int code;
    code = tbl[f3];
    if (f3 == 3'd0 && r_type && b30) code = 1;
    if (f3 == 3'd5 && b30) code = 8;
    return 4'(code);
  endfunction

  // Reference decoder organised per instruction format
  function automatic bnd_t ref_decode(input logic [31:0] ins);
    bnd_t b;
    logic [6:0] op;
    int s_i, s_s, s_b, s_j, s_u;
    op  = ins[6:0];
    s_i = int'($signed(ins[31:20]));
    s_s = int'($signed({ins[31:25], ins[11:7]}));
    s_b = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    s_j = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    s_u = int'($signed({ins[31:12], 12'b0}));
    b = '0;
    b.funct3 = ins[14:12];
    b.rd = ins[11:7];
    b.alu_src_b = 2'b01;
    case (op)
      7'b0110011: begin
        b.reg_write = 1; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.alu_src_b = 2'b00;
        b.alu_code = ref_alu(ins[14:12], ins[30], 1'b1);
`ifdef ILLEGAL_DETECT_EN
        if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) b.illegal = 1;
`endif
      end
      7'b0010011: begin
        b.reg_write = 1; b.rs1 = ins[19:15];
        b.alu_code = ref_alu(ins[14:12], ins[30], 1'b0);
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) b.imm = 32'(ins[25:20]);
        else b.imm = 32'(s_i);
      end
      7'b0000011: begin
        b.reg_write = 1; b.mem_read = 1; b.mem_to_reg = 1; b.rs1 = ins[19:15]; b.imm = 32'(s_i);
      end
      7'b0100011: begin
        b.mem_write = 1; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = 0; b.imm = 32'(s_s);
      end
      7'b1100011: begin
        b.sb_type = 1; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = 0; b.offset = 32'(s_b);
      end
      7'b1100111: begin
        b.reg_write = 1; b.jump = 1; b.jalr = 1; b.alu_src_a = 1; b.alu_src_b = 2'b10;
        b.rs1 = ins[19:15]; b.offset = 32'(s_i);
      end
      7'b1101111: begin
        b.reg_write = 1; b.jump = 1; b.alu_src_a = 1; b.alu_src_b = 2'b10; b.offset = 32'(s_j);
      end
      7'b0110111: begin
        b.reg_write = 1; b.alu_code = 4'd2; b.imm = 32'(s_u);
      end
      7'b0010111: begin
        b.reg_write = 1; b.alu_src_a = 1; b.imm = 32'(s_u);
      end
      default: begin
`ifdef ILLEGAL_DETECT_EN
        b.illegal = 1;
`endif
      end
    endcase
    if (b.illegal) begin
      b.reg_write = 0; b.mem_write = 0; b.mem_read = 0; b.jump = 0;
    end
    return b;
  endfunction

  // Instruction generator biased toward loads and low register numbers so interlocks occur often
  function automatic logic [31:0] gen_instr();
    logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b1100111,
                          7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 9) w[6:0] = ops[k];
    else if (k < 12) w[6:0] = 7'b0000011;
    w[19:15] = 5'($urandom_range(0, 6));
    w[24:20] = 5'($urandom_range(0, 6));
    w[11:7]  = 5'($urandom_range(0, 6));
    if (w[6:0] == 7'b0110011 && $urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid = v; Instruction = ins; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(1, I_ADD, 1, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    checks++; if (dut_bundle() !== bnd_t'(0)) begin errors++; $display("FAIL reset_bundle: got %h want 0", dut_bundle()); end
    reset = 0;
    drive(0, 32'h0, 1, 0);
  endtask

  task automatic test_add();
    drive(1, I_ADD, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (ALUCode !== 4'd0) begin errors++; $display("FAIL add_alucode: got %0d want 0", ALUCode); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL add_regwrite: got %b want 1", RegWrite); end
    checks++; if (rs1Addr !== 5'd10) begin errors++; $display("FAIL add_rs1: got %0d want 10", rs1Addr); end
    checks++; if (rs2Addr !== 5'd11) begin errors++; $display("FAIL add_rs2: got %0d want 11", rs2Addr); end
    checks++; if (rdAddr !== 5'd10) begin errors++; $display("FAIL add_rd: got %0d want 10", rdAddr); end
    checks++; if (ALUSrcB !== 2'b00) begin errors++; $display("FAIL add_alusrcb: got %b want 00", ALUSrcB); end
  endtask

  task automatic test_shift();
    drive(1, I_SRA, 1, 0);
    tick();
    checks++; if (ALUCode !== 4'd8) begin errors++; $display("FAIL sra_alucode: got %0d want 8", ALUCode); end
    drive(1, I_SRAI, 1, 0);
    tick();
    checks++; if (ALUCode !== 4'd8) begin errors++; $display("FAIL srai_alucode: got %0d want 8", ALUCode); end
    checks++; if (Imm !== 32'd1) begin errors++; $display("FAIL srai_imm: got %h want 1", Imm); end
    checks++; if (ALUSrcB !== 2'b01) begin errors++; $display("FAIL srai_alusrcb: got %b want 01", ALUSrcB); end
    drive(0, 32'h0, 1, 0);
    tick();
  endtask

  task automatic test_load_use();
    test_reset();
    drive(1, I_LW, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b1 || MemRead !== 1'b1 || rdAddr !== 5'd5) begin
      errors++; $display("FAIL lw_emit: got valid=%b memread=%b rd=%0d want 1 1 5", out_valid, MemRead, rdAddr); end
    drive(1, I_ADD2, 1, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    checks++; if (RegWrite !== 1'b0 || MemRead !== 1'b0) begin
      errors++; $display("FAIL bubble_ctrl: got regwrite=%b memread=%b want 0 0", RegWrite, MemRead); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL bubble_count: got %0d want 1", stall_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || rdAddr !== 5'd6 || rs1Addr !== 5'd5 || rs2Addr !== 5'd7) begin
      errors++; $display("FAIL add_after_load: got valid=%b rd=%0d rs1=%0d rs2=%0d want 1 6 5 7",
                         out_valid, rdAddr, rs1Addr, rs2Addr); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL count_after_add: got %0d want 1", stall_count); end
    drive(0, 32'h0, 1, 0);
    tick();
  endtask

  task automatic test_backpressure();
    bnd_t held;
    held = ref_decode(I_ADD);
    drive(1, I_ADD, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, I_SRA, 0, 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || dut_bundle() !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b %h want 1 %h", i, out_valid, dut_bundle(), held); end
    end
    drive(1, I_SRA, 1, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || dut_bundle() !== ref_decode(I_SRA)) begin
      errors++; $display("FAIL release_next: got %h want %h", dut_bundle(), ref_decode(I_SRA)); end
  endtask

  task automatic test_jal_flush();
    drive(1, I_JAL, 1, 0);
    tick();
    checks++; if (offset !== 32'hFFFFFFFC) begin errors++; $display("FAIL jal_offset: got %h want fffffffc", offset); end
    checks++; if (Jump !== 1'b1 || ALUSrcB !== 2'b10) begin
      errors++; $display("FAIL jal_ctrl: got jump=%b srcb=%b want 1 10", Jump, ALUSrcB); end
    drive(1, I_ADD, 1, 1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got valid=%b regwrite=%b want 0 0", out_valid, RegWrite); end
    drive(1, I_ADD, 1, 0);
    tick();
    drive(1, I_SRA, 0, 1);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    drive(1, 32'hFFFFFFFF, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b1 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL unknown_op: got valid=%b regwrite=%b memwrite=%b want 1 0 0", out_valid, RegWrite, MemWrite); end
`ifdef ILLEGAL_DETECT_EN
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", illegal); end
`endif
    drive(0, 32'h0, 1, 0);
    tick();
  endtask

  // Random traffic: model tracks the held bundle, its validity and the bubble count
  task automatic test_random();
    bnd_t  m_b, d;
    logic  m_v, h, rdy, v, ordy, fl;
    logic [31:0] ins;
    int    m_c;
    test_reset();
    m_b = '0; m_v = 0; m_c = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 15) == 0);
      ins  = gen_instr();
      drive(v, ins, ordy, fl);
      d   = ref_decode(ins);
      h   = m_v && m_b.mem_read && m_b.rd != 0 && v && (m_b.rd == d.rs1 || m_b.rd == d.rs2);
      rdy = (!m_v || ordy) && !h && !fl;
      checks++; if (in_ready !== rdy) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d: got %b want %b", cyc, in_ready, rdy); end
      tick();
      if (fl) begin
        m_v = 0;
      end else if (v && rdy) begin
        m_v = 1; m_b = d;
      end else if (ordy) begin
        if (h && m_c != 16'hFFFF) m_c++;
        m_v = 0;
      end
      checks++; if (out_valid !== m_v) begin
        errors++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, out_valid, m_v); end
      checks++; if (stall_count !== 16'(m_c)) begin
        errors++; $display("FAIL rnd_count cyc=%0d: got %0d want %0d", cyc, stall_count, m_c); end
      if (m_v) begin
        checks++; if (dut_bundle() !== m_b) begin
          errors++; $display("FAIL rnd_bundle cyc=%0d: got %h want %h", cyc, dut_bundle(), m_b); end
      end else begin
        checks++; if ({RegWrite, MemWrite, MemRead, Jump} !== 4'b0) begin
          errors++; $display("FAIL rnd_bubble cyc=%0d: got %b want 0000", cyc, {RegWrite, MemWrite, MemRead, Jump}); end
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; Instruction = 0; out_ready = 0; flush = 0;
    test_reset();
    test_add();
    test_shift();
    test_load_use();
    test_backpressure();
    test_jal_flush();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
